// File: rtl/rca_seg_sequencer.sv
// Multi-cycle wide adder controller: streams OP_W-bit operands through one shared
// SEG_W-bit ripple-carry adder, LSB segment first, carry chained through carry_q.
module rca_seg_sequencer #(
  parameter int SEG_W = 25,
  parameter int NSEG  = 4,
  localparam int OP_W = SEG_W * NSEG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_cin,
  output logic [SEG_W-1:0]  add_a,
  output logic [SEG_W-1:0]  add_b,
  output logic              add_cin,
  input  logic [SEG_W:0]    add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W:0]     out_sum,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  seg_idx;
  logic              carry_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  int                seg_base;
  logic              last_seg;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and a held valid keeps its payload stable.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign state_dbg = state;
  assign seg_base  = int'(seg_idx) * SEG_W;
  assign last_seg  = (seg_idx == IDX_W'(NSEG - 1));

  // Adder inputs are idle-zero outside RUN so the external adder sees no toggling.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_q[seg_base +: SEG_W];
      add_b   = b_q[seg_base +: SEG_W];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      seg_idx   <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            seg_idx <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          out_sum[seg_base +: SEG_W] <= add_sum[SEG_W-1:0];
          carry_q                    <= add_sum[SEG_W];
          if (last_seg) begin
            out_sum[OP_W] <= add_sum[SEG_W];
            seg_idx       <= '0;
            out_valid     <= 1'b1;
            state         <= S_DONE;
          end else begin
            seg_idx <= seg_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seg_sequencer.sv
// Bench for rca_seg_sequencer: behavioural adder, scoreboard of model sums,
// plus a second single-segment instance for the NSEG=1 corner.
module tb_rca_seg_sequencer;

  localparam int SEG_W = 25;
  localparam int NSEG  = 4;
  localparam int OP_W  = SEG_W * NSEG;
  localparam int TMO   = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- main DUT (NSEG=4) ----------------
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_a = '0;
  logic [OP_W-1:0]   in_b = '0;
  logic              in_cin = 1'b0;
  logic [SEG_W-1:0]  add_a, add_b;
  logic              add_cin;
  logic [SEG_W:0]    add_sum;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OP_W:0]     out_sum;
  logic [1:0]        state_dbg;

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{SEG_W{1'b0}}, add_cin};

  rca_seg_sequencer #(.SEG_W(SEG_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .state_dbg(state_dbg)
  );

  // ---------------- single-segment DUT (NSEG=1) ----------------
  logic              s1_in_valid = 1'b0;
  logic              s1_in_ready;
  logic [SEG_W-1:0]  s1_in_a = '0;
  logic [SEG_W-1:0]  s1_in_b = '0;
  logic              s1_in_cin = 1'b0;
  logic [SEG_W-1:0]  s1_add_a, s1_add_b;
  logic              s1_add_cin;
  logic [SEG_W:0]    s1_add_sum;
  logic              s1_out_valid;
  logic              s1_out_ready = 1'b1;
  logic [SEG_W:0]    s1_out_sum;
  logic [1:0]        s1_state_dbg;

  assign s1_add_sum = {1'b0, s1_add_a} + {1'b0, s1_add_b} + {{SEG_W{1'b0}}, s1_add_cin};

  rca_seg_sequencer #(.SEG_W(SEG_W), .NSEG(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_a(s1_in_a), .in_b(s1_in_b), .in_cin(s1_in_cin),
    .add_a(s1_add_a), .add_b(s1_add_b), .add_cin(s1_add_cin), .add_sum(s1_add_sum),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum),
    .state_dbg(s1_state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OP_W:0] model_add(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                              input logic cin);
    return {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
  endfunction

  // ---------------- scoreboard ----------------
  logic [OP_W:0] exp_q[$];
  bit            chk_interval = 1'b0;
  int            last_out_cycle = -1;

  // Outputs are sampled on the falling edge; valid && ready here means the
  // result transfers on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 128'(out_sum), 128'(0));
      end else begin
        check_eq("result", 128'(out_sum), 128'(exp_q.pop_front()));
      end
      if (chk_interval && last_out_cycle >= 0)
        check_eq("issue_interval", 128'(cycle - last_out_cycle), 128'(NSEG + 2));
      last_out_cycle = cycle;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one operand set and returns #1 after the accepting edge.
  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic cin,
                      input bit push_exp);
    int waited = 0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TMO) check_eq("send_timeout", 128'(0), 128'(1));
    @(posedge clk);
    if (push_exp) exp_q.push_back(model_add(a, b, cin));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int waited = 0;
    while (!out_valid && waited < TMO) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= TMO) check_eq("out_valid_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[OP_W-1:0];
  endfunction

  logic [OP_W-1:0] all_ones;
  logic [OP_W:0]   held;

  initial begin
    all_ones = '1;

    // 1. reset
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_out_valid", 128'(out_valid), 128'(0));
      check_eq("rst_out_sum", 128'(out_sum), 128'(0));
      check_eq("rst_in_ready", 128'(in_ready), 128'(0));
    end
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", 128'(in_ready), 128'(1));
    check_eq("idle_add_a", 128'(add_a), 128'(0));
    check_eq("idle_add_b", 128'(add_b), 128'(0));
    check_eq("idle_add_cin", 128'(add_cin), 128'(0));

    // 2. full carry ripple: (2^100-1) + 1
    send(all_ones, 100'd1, 1'b0, 1'b1);
    for (int k = 0; k < NSEG; k++) begin
      check_eq($sformatf("ripple_add_cin_%0d", k), 128'(add_cin), 128'(k == 0 ? 0 : 1));
      check_eq($sformatf("ripple_no_valid_%0d", k), 128'(out_valid), 128'(0));
      check_eq($sformatf("ripple_in_ready_%0d", k), 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    check_eq("ripple_latency_valid", 128'(out_valid), 128'(1));
    check_eq("ripple_sum", 128'(out_sum), 128'(101'd1 << 100));
    check_eq("done_add_a", 128'(add_a), 128'(0));
    @(posedge clk); #1;

    // 3. all-ones with carry-in, then random back-to-back
    send(all_ones, all_ones, 1'b1, 1'b1);
    wait_out_valid();
    check_eq("max_sum", 128'(out_sum), 128'({1'b1, all_ones}));
    @(posedge clk); #1;
    last_out_cycle = -1;
    chk_interval = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b1);
    wait_out_valid();
    @(posedge clk); #1;
    chk_interval = 1'b0;

    // 4. backpressure in DONE
    out_ready = 1'b0;
    send(rand_op(), rand_op(), 1'b1, 1'b1);
    wait_out_valid();
    held = out_sum;
    check_eq("bp_sum_model", 128'(held), 128'(exp_q[0]));
    for (int k = 0; k < 5; k++) begin
      in_a = rand_op(); in_b = rand_op(); in_valid = k[0];
      @(posedge clk); #1;
      check_eq("bp_valid_held", 128'(out_valid), 128'(1));
      check_eq("bp_sum_held", 128'(out_sum), 128'(held));
      check_eq("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_idle", 128'(in_ready), 128'(1));
    check_eq("bp_release_valid", 128'(out_valid), 128'(0));
    send(100'h123_4567_89ab_cdef, 100'hf_0000_0000_0000_0001, 1'b0, 1'b1);
    wait_out_valid();
    @(posedge clk); #1;

    // 5. reset during the third RUN cycle discards the partial result
    send(all_ones, 100'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check_eq("midrst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_sum_cleared", 128'(out_sum), 128'(0));
    for (int k = 0; k < 2 * NSEG; k++) begin
      check_eq("midrst_no_valid", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
    end
    send(100'd5, 100'd7, 1'b0, 1'b1);
    wait_out_valid();
    check_eq("post_rst_sum", 128'(out_sum), 128'(12));
    @(posedge clk); #1;

    // 6. single-segment instance: (2^25-1) + 1 completes one edge after accept
    s1_in_a = '1; s1_in_b = 25'd1; s1_in_cin = 1'b0; s1_in_valid = 1'b1;
    begin
      int waited = 0;
      @(negedge clk);
      while (!s1_in_ready && waited < TMO) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= TMO) check_eq("s1_send_timeout", 128'(0), 128'(1));
    end
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    check_eq("s1_run_no_valid", 128'(s1_out_valid), 128'(0));
    @(posedge clk); #1;
    check_eq("s1_valid", 128'(s1_out_valid), 128'(1));
    check_eq("s1_sum", 128'(s1_out_sum), 128'(26'd1 << 25));
    @(posedge clk); #1;
    check_eq("s1_back_idle", 128'(s1_in_ready), 128'(1));

    // drain
    begin
      int waited = 0;
      while (exp_q.size() != 0 && waited < TMO) begin
        @(posedge clk);
        waited++;
      end
    end
    check_eq("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a wedged run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
